ifetch: RTL and testbench

Instruction-fetch stage of the riscv_core pipeline: owns the word-addressed PC, drives the synchronous IMEM read port, and presents `pc_o`/`inst_o`/`valid_o` to the decode stage. Zero-bubble redirect: the combinational branch/jump resolution from decode is muxed straight onto the IMEM address. Stalls are handled by re-issuing the held address, with a pending-redirect register for redirects that arrive during a stall. Also keeps a fetched-instruction counter for performance CSRs.

---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/ifetch_pc_next_mux.sv | 38 +++
 rtl/ifetch.sv | 109 ++++++++++
 tb/tb_ifetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch top level and by the next-address mux.
package ifetch_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0400_0000;
  localparam logic [31:0] NopInst        = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SelHold     = 2'd0,
    SelRedirect = 2'd1,
    SelPending  = 2'd2,
    SelIncr     = 2'd3
  } addr_sel_e;

  // Word-address increment; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/ifetch_pc_next_mux.sv
// Priority select of the next fetch address: stall hold, live redirect,
// pending redirect, then sequential increment.
module pc_next_mux
  import ifetch_pkg::*;
(
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        pend_v_i,
  input  logic [31:0] pend_addr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_addr_o
);

  addr_sel_e sel;

  always_comb begin
    sel = SelIncr;
    if (stall_i) begin
      sel = SelHold;
    end else if (redirect_i) begin
      sel = SelRedirect;
    end else if (pend_v_i) begin
      sel = SelPending;
    end
  end

  always_comb begin
    next_addr_o = pc_i;
    unique case (sel)
      SelHold:     next_addr_o = pc_i;
      SelRedirect: next_addr_o = redirect_addr_i;
      SelPending:  next_addr_o = pend_addr_i;
      SelIncr:     next_addr_o = pc_incr(pc_i);
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the word PC, drives the synchronous IMEM port
// with zero-bubble redirects, and counts instructions accepted by decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_en_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  mux_addr;
  logic         booting;

  assign booting = (state_q == StBoot);

  pc_next_mux u_pc_next_mux (
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .pend_v_i        (pend_v_q),
    .pend_addr_i     (pend_addr_q),
    .pc_i            (pc_q),
    .next_addr_o     (mux_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = stall_i ? StStall : StRun;
      StStall: state_d = stall_i ? StStall : StRun;
      default: state_d = StBoot;
    endcase
  end

  // Outputs
  always_comb begin
    imem_en_o   = rst_n;
    valid_o     = !booting;
    inst_o      = booting ? NOP_INST : imem_data_i;
    imem_addr_o = (!rst_n || booting) ? RESET_PC : mux_addr;
    pc_o        = pc_q;
    fetch_cnt_o = cnt_q;
  end

  // A redirect that lands during a stall is parked until the stall lifts;
  // the first unstalled cycle consumes or supersedes it.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    if (!booting) begin
      if (stall_i && redirect_i) begin
        pend_v_d    = 1'b1;
        pend_addr_d = redirect_addr_i;
      end else if (!stall_i) begin
        pend_v_d = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_o && !stall_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'h0;
      cnt_q       <= 32'h0;
    end else begin
      pc_q        <= imem_addr_o;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: table of per-cycle stimulus and expected outputs, a queue
// of issued addresses checked against pc_o/inst_o, and a reset-mid-stall sequence.
module tb_ifetch;

  localparam logic [31:0] B   = 32'h0400_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned NumVec = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic [31:0] imem_addr_o;
  logic        imem_en_o;
  logic [31:0] imem_data;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic [31:0] fetch_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_addr_o     (imem_addr_o),
    .imem_en_o       (imem_en_o),
    .imem_data_i     (imem_data),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Synchronous IMEM model
  always @(posedge clk) begin
    if (imem_en_o) imem_data <= memf(imem_addr_o);
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t        vecs[NumVec];
  logic [31:0] sb_q[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] ra,
                              input logic [31:0] ea, input logic [31:0] ep,
                              input logic ev, input logic [31:0] ec);
    vec_t v;
    v.stall = s; v.redir = r; v.raddr = ra;
    v.exp_addr = ea; v.exp_pc = ep; v.exp_valid = ev; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    // stall, redir, raddr, exp imem_addr, exp pc, exp valid, exp count
    vecs[0]  = mk(0, 0, 0,          B,            B,            0, 0);
    vecs[1]  = mk(0, 0, 0,          B + 1,        B,            1, 0);
    vecs[2]  = mk(0, 0, 0,          B + 2,        B + 1,        1, 1);
    vecs[3]  = mk(0, 0, 0,          B + 3,        B + 2,        1, 2);
    vecs[4]  = mk(1, 0, 0,          B + 3,        B + 3,        1, 3);
    vecs[5]  = mk(1, 0, 0,          B + 3,        B + 3,        1, 3);
    vecs[6]  = mk(1, 0, 0,          B + 3,        B + 3,        1, 3);
    vecs[7]  = mk(0, 0, 0,          B + 4,        B + 3,        1, 3);
    vecs[8]  = mk(0, 0, 0,          B + 5,        B + 4,        1, 4);
    vecs[9]  = mk(0, 1, B + 'h10,   B + 'h10,     B + 5,        1, 5);
    vecs[10] = mk(0, 0, 0,          B + 'h11,     B + 'h10,     1, 6);
    vecs[11] = mk(1, 1, B + 'h20,   B + 'h11,     B + 'h11,     1, 7);
    vecs[12] = mk(1, 0, 0,          B + 'h11,     B + 'h11,     1, 7);
    vecs[13] = mk(1, 0, 0,          B + 'h11,     B + 'h11,     1, 7);
    vecs[14] = mk(0, 0, 0,          B + 'h20,     B + 'h11,     1, 7);
    vecs[15] = mk(0, 0, 0,          B + 'h21,     B + 'h20,     1, 8);
    vecs[16] = mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, B + 'h21, 1, 9);
    vecs[17] = mk(0, 0, 0,          32'h0,        32'hFFFF_FFFF, 1, 10);
    vecs[18] = mk(1, 1, B + 'h30,   32'h0,        32'h0,        1, 11);
    vecs[19] = mk(1, 1, B + 'h50,   32'h0,        32'h0,        1, 11);
    vecs[20] = mk(0, 0, 0,          B + 'h50,     32'h0,        1, 11);
    vecs[21] = mk(1, 1, B + 'h60,   B + 'h50,     B + 'h50,     1, 12);
    vecs[22] = mk(0, 1, B + 'h70,   B + 'h70,     B + 'h50,     1, 12);
    vecs[23] = mk(0, 0, 0,          B + 'h71,     B + 'h70,     1, 13);
    vecs[24] = mk(0, 0, 0,          B + 'h72,     B + 'h71,     1, 14);

    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
    step();
    step();
    chk("rst_en",    {31'h0, imem_en_o}, 32'h0);
    chk("rst_addr",  imem_addr_o, B);
    chk("rst_pc",    pc_o, B);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_inst",  inst_o, NOP);
    chk("rst_cnt",   fetch_cnt_o, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      stall_i = vecs[i].stall;
      redirect_i = vecs[i].redir;
      redirect_addr_i = vecs[i].raddr;
      #1;
      chk($sformatf("v%0d_addr", i),  imem_addr_o, vecs[i].exp_addr);
      chk($sformatf("v%0d_pc", i),    pc_o, vecs[i].exp_pc);
      chk($sformatf("v%0d_valid", i), {31'h0, valid_o}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_cnt", i),   fetch_cnt_o, vecs[i].exp_cnt);
      chk($sformatf("v%0d_en", i),    {31'h0, imem_en_o}, 32'h1);
      if (!vecs[i].exp_valid) chk($sformatf("v%0d_nop", i), inst_o, NOP);
      if (i > 0) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL v%0d_sb: got empty queue want entry", i);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d_sb_pc", i), pc_o, e);
          if (vecs[i].exp_valid) chk($sformatf("v%0d_sb_inst", i), inst_o, memf(e));
        end
      end
      sb_q.push_back(vecs[i].exp_addr);
      step();
    end

    // Reset in the middle of a stall with a redirect parked
    stall_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = B + 'h99;
    #1;
    chk("hs_stall_addr", imem_addr_o, B + 'h72);
    step();
    rst_n = 1'b0; redirect_i = 1'b0;
    #1;
    chk("hs_rst_en",   {31'h0, imem_en_o}, 32'h0);
    chk("hs_rst_addr", imem_addr_o, B);
    step();
    // BOOT: stall and redirect must be ignored
    rst_n = 1'b1; redirect_i = 1'b1; redirect_addr_i = B + 'h55;
    #1;
    chk("hs_boot_addr",  imem_addr_o, B);
    chk("hs_boot_valid", {31'h0, valid_o}, 32'h0);
    chk("hs_boot_cnt",   fetch_cnt_o, 32'h0);
    chk("hs_boot_pc",    pc_o, B);
    chk("hs_boot_inst",  inst_o, NOP);
    chk("hs_boot_en",    {31'h0, imem_en_o}, 32'h1);
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    #1;
    chk("hs_run_pc",    pc_o, B);
    chk("hs_run_valid", {31'h0, valid_o}, 32'h1);
    chk("hs_run_inst",  inst_o, memf(B));
    chk("hs_run_addr",  imem_addr_o, B + 1);
    chk("hs_run_cnt",   fetch_cnt_o, 32'h0);
    step();
    chk("hs_next_pc",  pc_o, B + 1);
    chk("hs_next_cnt", fetch_cnt_o, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
